chirp_analyzer: RTL

CHIRP_ANALYZER -- requirements
Module: chirp_analyzer

---
 rtl/chirp_analyzer_pkg.sv | 25 ++
 rtl/chirp_analyzer_if.sv | 31 +++
 rtl/zc_detect.sv | 44 ++++
 rtl/chirp_analyzer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/chirp_analyzer_pkg.sv
// Shared types and defaults for the chirp analyzer.
package chirp_analyzer_pkg;

  localparam int unsigned DefM = 16;
  localparam int unsigned DefP = 24;

  // Hysteresis comparator state.
  typedef enum logic [1:0] {
    CmpUnk,
    CmpLo,
    CmpHi
  } cmp_state_e;

  // Chirp tracking state.
  typedef enum logic [1:0] {
    StIdle,
    StFirst,
    StTrack
  } chirp_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/chirp_analyzer_if.sv
// Sample input, configuration and measurement results of the chirp analyzer.
interface chirp_analyzer_if
  import chirp_analyzer_pkg::*;
#(
  parameter int unsigned M = DefM,
  parameter int unsigned P = DefP
) ();

  logic signed [M-1:0] sample;
  logic                sample_en;
  logic [M-2:0]        hyst;
  logic [P-1:0]        timeout;
  logic [P-1:0]        period;
  logic                period_valid;
  logic                chirp_done;
  logic                chirp_reverse;
  logic [P-1:0]        min_period;
  logic [P-1:0]        max_period;
  logic [15:0]         n_periods;

  modport master (
    output sample, sample_en, hyst, timeout,
    input  period, period_valid, chirp_done, chirp_reverse, min_period, max_period, n_periods
  );

  modport slave (
    input  sample, sample_en, hyst, timeout,
    output period, period_valid, chirp_done, chirp_reverse, min_period, max_period, n_periods
  );

endinterface

// File: rtl/zc_detect.sv
// Hysteresis comparator producing a one-cycle strobe on each LO->HI transition.
module zc_detect
  import chirp_analyzer_pkg::*;
#(
  parameter int unsigned M = DefM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [M-1:0] sample,
  input  logic                sample_en,
  input  logic [M-2:0]        hyst,
  output logic                crossing
);

  cmp_state_e         state_q, state_d;
  logic signed [M:0]  sample_x, hyst_pos, hyst_neg;

  // Threshold compare at M+1 bits so -hyst never overflows; crossing is combinational.
  always_comb begin
    sample_x = {sample[M-1], sample};
    hyst_pos = {2'b00, hyst};
    hyst_neg = -hyst_pos;
    state_d  = state_q;
    if (sample_en) begin
      if (sample_x > hyst_pos) begin
        state_d = CmpHi;
      end else if (sample_x < hyst_neg) begin
        state_d = CmpLo;
      end
    end
    // UNK->HI is deliberately not a crossing.
    crossing = (state_q == CmpLo) && (state_d == CmpHi);
  end

  // Comparator state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CmpUnk;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/chirp_analyzer.sv
// Measures crossing-to-crossing periods and summarises each chirp at its timeout.
module chirp_analyzer
  import chirp_analyzer_pkg::*;
#(
  parameter int unsigned M = DefM,
  parameter int unsigned P = DefP
) (
  input logic             clk,
  input logic             rst,
  chirp_analyzer_if.slave bus
);

  logic crossing;

  zc_detect #(.M(M)) u_zc_detect (
    .clk       (clk),
    .rst       (rst),
    .sample    (bus.sample),
    .sample_en (bus.sample_en),
    .hyst      (bus.hyst),
    .crossing  (crossing)
  );

  chirp_state_e state_q, state_d;
  logic [P-1:0] gap_q, gap_d;
  logic [P:0]   gap_inc;
  logic [P-1:0] new_period;
  logic         expired;
  logic         clear_work;
  logic [P-1:0] prev_q, prev_d, wmin_q, wmin_d, wmax_q, wmax_d;
  logic [15:0]  wcnt_q, wcnt_d, inc_q, inc_d, dec_q, dec_d;
  logic [P-1:0] period_q, period_d, min_q, min_d, max_q, max_d;
  logic [15:0]  n_q, n_d;
  logic         period_valid_q, period_valid_d;
  logic         chirp_done_q, chirp_done_d;
  logic         reverse_q, reverse_d;

  // Cycles since the last crossing, counting the current one.
  assign gap_inc    = {1'b0, gap_q} + 1'b1;
  assign new_period = gap_inc[P] ? {P{1'b1}} : gap_inc[P-1:0];
  assign expired    = (bus.timeout != '0) && (gap_inc >= {1'b0, bus.timeout});

  // Gap counter: free-running, cleared on crossing, saturating.
  always_comb begin
    gap_d = gap_q;
    if (crossing) begin
      gap_d = '0;
    end else if (!(&gap_q)) begin
      gap_d = gap_q + 1'b1;
    end
  end

  // Chirp FSM plus working-register and result updates; a crossing beats expiry.
  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    wmin_d         = wmin_q;
    wmax_d         = wmax_q;
    wcnt_d         = wcnt_q;
    inc_d          = inc_q;
    dec_d          = dec_q;
    period_d       = period_q;
    min_d          = min_q;
    max_d          = max_q;
    n_d            = n_q;
    reverse_d      = reverse_q;
    period_valid_d = 1'b0;
    chirp_done_d   = 1'b0;
    clear_work     = 1'b0;
    case (state_q)
      StIdle: begin
        if (crossing) begin
          state_d    = StFirst;
          clear_work = 1'b1;
        end
      end
      StFirst: begin
        if (crossing) begin
          state_d        = StTrack;
          period_d       = new_period;
          period_valid_d = 1'b1;
          prev_d         = new_period;
          wmin_d         = new_period;
          wmax_d         = new_period;
          wcnt_d         = 16'd1;
        end else if (expired) begin
          state_d    = StIdle;
          clear_work = 1'b1;
        end
      end
      StTrack: begin
        if (crossing) begin
          period_d       = new_period;
          period_valid_d = 1'b1;
          prev_d         = new_period;
          wcnt_d         = sat_inc16(wcnt_q);
          if (new_period < prev_q) dec_d = sat_inc16(dec_q);
          if (new_period > prev_q) inc_d = sat_inc16(inc_q);
          if (new_period < wmin_q) wmin_d = new_period;
          if (new_period > wmax_q) wmax_d = new_period;
        end else if (expired) begin
          state_d      = StIdle;
          chirp_done_d = 1'b1;
          reverse_d    = inc_q > dec_q;
          min_d        = wmin_q;
          max_d        = wmax_q;
          n_d          = wcnt_q;
          clear_work   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (clear_work) begin
      prev_d = '0;
      wmin_d = '0;
      wmax_d = '0;
      wcnt_d = '0;
      inc_d  = '0;
      dec_d  = '0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      gap_q          <= '0;
      prev_q         <= '0;
      wmin_q         <= '0;
      wmax_q         <= '0;
      wcnt_q         <= '0;
      inc_q          <= '0;
      dec_q          <= '0;
      period_q       <= '0;
      min_q          <= '0;
      max_q          <= '0;
      n_q            <= '0;
      reverse_q      <= 1'b0;
      period_valid_q <= 1'b0;
      chirp_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      gap_q          <= gap_d;
      prev_q         <= prev_d;
      wmin_q         <= wmin_d;
      wmax_q         <= wmax_d;
      wcnt_q         <= wcnt_d;
      inc_q          <= inc_d;
      dec_q          <= dec_d;
      period_q       <= period_d;
      min_q          <= min_d;
      max_q          <= max_d;
      n_q            <= n_d;
      reverse_q      <= reverse_d;
      period_valid_q <= period_valid_d;
      chirp_done_q   <= chirp_done_d;
    end
  end

  assign bus.period        = period_q;
  assign bus.period_valid  = period_valid_q;
  assign bus.chirp_done    = chirp_done_q;
  assign bus.chirp_reverse = reverse_q;
  assign bus.min_period    = min_q;
  assign bus.max_period    = max_q;
  assign bus.n_periods     = n_q;

endmodule
